mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: memory dump controller in front of a data-memory SRAM.
// In IDLE the CPU data-memory request passes straight through to the SRAM.
// On a halt, a manual start or watchdog expiry, the block takes over the
// SRAM port and streams WORD_COUNT words from BASE_ADDR out over a
// valid/ready interface.
// A dump takes three cycles per word: REQ presents the address, WAIT
// captures the read data, and OUT holds the beat until it is accepted.
module mem_dump_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int BASE_ADDR      = 0,
  parameter int WORD_COUNT     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_w_en_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_w_en_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                dump_valid_o,
  input  logic                dump_ready_i,
  output logic [ADDR_W-1:0]   dump_addr_o,
  output logic [DATA_W-1:0]   dump_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);

  // idx covers the full WORD_COUNT range of 1..65535.
  localparam int IDX_W = 16;
  localparam int WD_W  = 32;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_COUNT - 1);
  localparam bit                WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [WD_W-1:0]    wdog, wdog_n;
  logic               timeout_q, timeout_n;
  logic [ADDR_W-1:0]  dump_addr_q;
  logic [DATA_W-1:0]  dump_data_q;
  logic               capture;
  logic [ADDR_W-1:0]  cur_addr;

  // Word address being dumped; the byte offset wraps modulo 2^ADDR_W.
  assign cur_addr = BASE + ADDR_W'({idx, 2'b00});

  // State register, counters and captured dump beat.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wdog        <= '0;
      timeout_q   <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      wdog      <= wdog_n;
      timeout_q <= timeout_n;
      if (capture) begin
        dump_addr_q <= cur_addr;
        dump_data_q <= mem_rdata_i;
      end
    end
  end

  // Next-state logic: triggers, watchdog, beat sequencing.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wdog_n    = wdog;
    timeout_n = timeout_q;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (halt_i || start_i) begin
          // A real trigger wins over a coincident watchdog expiry.
          state_n = REQ;
          idx_n   = '0;
          wdog_n  = '0;
        end else if (WD_EN && (wdog == WD_LIMIT)) begin
          state_n   = REQ;
          idx_n     = '0;
          wdog_n    = '0;
          timeout_n = 1'b1;
        end else if (WD_EN) begin
          wdog_n = wdog + 1'b1;
        end
      end
      REQ: begin
        state_n = WAIT;
      end
      WAIT: begin
        // SRAM data for the address presented in REQ is valid now.
        capture = 1'b1;
        state_n = OUT;
      end
      OUT: begin
        if (dump_ready_i) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = REQ;
          end
        end
      end
      DONE: begin
        // Halt is ignored here; only a manual start repeats the dump.
        if (start_i) begin
          state_n = REQ;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // SRAM port mux and status outputs, decoded from the state register so
  // a reset releases the SRAM back to the CPU in the same cycle.
  always_comb begin
    mem_addr_o   = cpu_addr_i;
    mem_w_en_o   = cpu_w_en_i;
    mem_wdata_o  = cpu_wdata_i;
    dump_valid_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    if (state != IDLE) begin
      mem_addr_o  = cur_addr;
      mem_w_en_o  = {BE_W{1'b0}};
      mem_wdata_o = '0;
    end
    case (state)
      REQ, WAIT: busy_o = 1'b1;
      OUT: begin
        busy_o       = 1'b1;
        dump_valid_o = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign dump_addr_o = dump_addr_q;
  assign dump_data_o = dump_data_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Testbench for mem_dump_ctrl: two instances (default parameters, and a
// wrapped-address / short-watchdog configuration), each with a one-cycle
// latency SRAM model returning word n = n+100 and a scoreboard monitor.
module tb_mem_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared CPU request.
  logic [15:0] cpu_addr;
  logic [3:0]  cpu_w_en;
  logic [31:0] cpu_wdata;

  // Instance A signals (default parameters).
  logic        rst_a, halt_a, start_a, ready_a;
  logic [15:0] mem_addr_a, dump_addr_a;
  logic [3:0]  mem_w_en_a;
  logic [31:0] mem_wdata_a, rdata_a, dump_data_a;
  logic        valid_a, busy_a, done_a, timeout_a;

  // Instance B signals (BASE_ADDR=FFF8, WORD_COUNT=4, TIMEOUT_CYCLES=8).
  logic        rst_b, halt_b, start_b, ready_b;
  logic [15:0] mem_addr_b, dump_addr_b;
  logic [3:0]  mem_w_en_b;
  logic [31:0] mem_wdata_b, rdata_b, dump_data_b;
  logic        valid_b, busy_b, done_b, timeout_b;

  mem_dump_ctrl u_a (
    .clk(clk), .rst(rst_a), .halt_i(halt_a), .start_i(start_a),
    .cpu_addr_i(cpu_addr), .cpu_w_en_i(cpu_w_en), .cpu_wdata_i(cpu_wdata),
    .mem_addr_o(mem_addr_a), .mem_w_en_o(mem_w_en_a), .mem_wdata_o(mem_wdata_a),
    .mem_rdata_i(rdata_a),
    .dump_valid_o(valid_a), .dump_ready_i(ready_a),
    .dump_addr_o(dump_addr_a), .dump_data_o(dump_data_a),
    .busy_o(busy_a), .done_o(done_a), .timeout_o(timeout_a)
  );

  mem_dump_ctrl #(
    .ADDR_W(16), .DATA_W(32), .BASE_ADDR('hFFF8), .WORD_COUNT(4), .TIMEOUT_CYCLES(8)
  ) u_b (
    .clk(clk), .rst(rst_b), .halt_i(halt_b), .start_i(start_b),
    .cpu_addr_i(cpu_addr), .cpu_w_en_i(cpu_w_en), .cpu_wdata_i(cpu_wdata),
    .mem_addr_o(mem_addr_b), .mem_w_en_o(mem_w_en_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(rdata_b),
    .dump_valid_o(valid_b), .dump_ready_i(ready_b),
    .dump_addr_o(dump_addr_b), .dump_data_o(dump_data_b),
    .busy_o(busy_b), .done_o(done_b), .timeout_o(timeout_b)
  );

  // SRAM models: synchronous read, word n holds n+100.
  always @(posedge clk) begin
    rdata_a <= 32'(mem_addr_a >> 2) + 32'd100;
    rdata_b <= 32'(mem_addr_b >> 2) + 32'd100;
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];

  int n_cmp = 0;
  int n_err = 0;
  int beats_a = 0, beats_b = 0;
  int wen_viol_a = 0, wen_viol_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor A: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!rst_a && valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_beat: got addr 0x%0h data %0d, expected no beat", dump_addr_a, dump_data_a);
      end else begin
        beat_t e;
        e = q_a.pop_front();
        check("a_beat_addr", 64'(dump_addr_a), 64'(e.addr));
        check("a_beat_data", 64'(dump_data_a), 64'(e.data));
      end
      beats_a++;
    end
    if (!rst_a && (busy_a || done_a) && (mem_w_en_a != 4'h0)) wen_viol_a++;
  end

  // Monitor B: same scoreboard scheme for the second instance.
  always @(negedge clk) begin
    if (!rst_b && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_beat: got addr 0x%0h data %0d, expected no beat", dump_addr_b, dump_data_b);
      end else begin
        beat_t e;
        e = q_b.pop_front();
        check("b_beat_addr", 64'(dump_addr_b), 64'(e.addr));
        check("b_beat_data", 64'(dump_data_b), 64'(e.data));
      end
      beats_b++;
    end
    if (!rst_b && (busy_b || done_b) && (mem_w_en_b != 4'h0)) wen_viol_b++;
  end

  task automatic push_a10();
    for (int i = 0; i < 10; i++) q_a.push_back({16'(4 * i), 32'(100 + i)});
  endtask

  task automatic push_b4();
    q_b.push_back({16'hFFF8, 32'd16482});
    q_b.push_back({16'hFFFC, 32'd16483});
    q_b.push_back({16'h0000, 32'd100});
    q_b.push_back({16'h0004, 32'd101});
  endtask

  task automatic wait_done_a(input int limit);
    int c = 0;
    while (!done_a && c < limit) begin
      tick(1);
      c++;
    end
    check("a_done_reached", 64'(done_a), 64'd1);
  endtask

  task automatic wait_done_b(input int limit);
    int c = 0;
    while (!done_b && c < limit) begin
      tick(1);
      c++;
    end
    check("b_done_reached", 64'(done_b), 64'd1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_valid"},   64'(valid_a),     64'd0);
    check({tag, "_busy"},    64'(busy_a),      64'd0);
    check({tag, "_done"},    64'(done_a),      64'd0);
    check({tag, "_timeout"}, 64'(timeout_a),   64'd0);
    check({tag, "_daddr"},   64'(dump_addr_a), 64'd0);
    check({tag, "_ddata"},   64'(dump_data_a), 64'd0);
  endtask

  task automatic check_pass_a(input string tag);
    check({tag, "_maddr"},  64'(mem_addr_a),  64'h40);
    check({tag, "_mwen"},   64'(mem_w_en_a),  64'hF);
    check({tag, "_mwdata"}, 64'(mem_wdata_a), 64'hDEADBEEF);
  endtask

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  // Directed stimulus.
  initial begin
    int base_beats;
    int cyc;
    int found;
    int k;

    rst_a = 1'b1; rst_b = 1'b1;
    halt_a = 1'b0; start_a = 1'b0; ready_a = 1'b1;
    halt_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;
    cpu_addr = 16'h0040; cpu_w_en = 4'hF; cpu_wdata = 32'hDEADBEEF;

    // Reset state and CPU passthrough.
    #2;
    check_zero_a("a_rst");
    tick(2);
    rst_a = 1'b0;
    tick(1);
    check_pass_a("a_idle_pass");

    // Halt-triggered dump with ready held high; latency bound.
    push_a10();
    base_beats = beats_a;
    halt_a = 1'b1;
    tick(1);
    halt_a = 1'b0;
    check("a_busy_after_trig", 64'(busy_a), 64'd1);
    cyc = 1;
    while (!done_a && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check("a_done_within_31", 64'(cyc <= 31), 64'd1);
    check("a_done_1", 64'(done_a), 64'd1);
    check("a_busy_in_done", 64'(busy_a), 64'd0);
    check("a_beats_1", 64'(beats_a - base_beats), 64'd10);
    check("a_queue_empty_1", 64'(q_a.size()), 64'd0);

    // Halt is ignored in DONE.
    halt_a = 1'b1;
    tick(1);
    halt_a = 1'b0;
    tick(3);
    check("a_halt_ignored_done", 64'(done_a), 64'd1);
    check("a_halt_ignored_beats", 64'(beats_a - base_beats), 64'd10);

    // Restart from DONE with back-pressure on beat 3.
    push_a10();
    base_beats = beats_a;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    k = 0;
    while (!(valid_a && dump_addr_a == 16'd12) && k < 100) begin
      tick(1);
      k++;
    end
    check("a_bp_beat3_seen", 64'(valid_a && dump_addr_a == 16'd12), 64'd1);
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("a_bp_valid", 64'(valid_a),     64'd1);
      check("a_bp_addr",  64'(dump_addr_a), 64'd12);
      check("a_bp_data",  64'(dump_data_a), 64'd103);
      tick(1);
    end
    ready_a = 1'b1;
    wait_done_a(60);
    check("a_beats_2", 64'(beats_a - base_beats), 64'd10);
    check("a_queue_empty_2", 64'(q_a.size()), 64'd0);
    check("a_timeout_stays_0", 64'(timeout_a), 64'd0);
    check("a_no_mem_write", 64'(wen_viol_a), 64'd0);

    // Reset during WAIT of beat 5 aborts the dump.
    push_a10();
    base_beats = beats_a;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    found = 0;
    k = 0;
    while (found < 2 && k < 200) begin
      if (busy_a && !valid_a && mem_addr_a == 16'd20) found++;
      if (found < 2) tick(1);
      k++;
    end
    check("a_wait5_seen", 64'(found), 64'd2);
    rst_a = 1'b1;
    #1;
    check_zero_a("a_abort");
    check_pass_a("a_abort_pass");
    check("a_abort_beats", 64'(beats_a - base_beats), 64'd5);
    check("a_abort_left", 64'(q_a.size()), 64'd5);
    q_a.delete();
    tick(2);
    rst_a = 1'b0;
    tick(1);
    check("a_abort_no_more", 64'(beats_a - base_beats), 64'd5);

    // Halt and start together start exactly one full dump from BASE_ADDR.
    push_a10();
    base_beats = beats_a;
    start_a = 1'b1;
    halt_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    halt_a = 1'b0;
    wait_done_a(60);
    tick(5);
    check("a_beats_3", 64'(beats_a - base_beats), 64'd10);
    check("a_queue_empty_3", 64'(q_a.size()), 64'd0);
    rst_a = 1'b1;

    // Watchdog expiry with no trigger, then wrapped-address dump.
    push_b4();
    tick(1);
    rst_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) check("b_timeout_cyc7", 64'(timeout_b), 64'd0);
    end
    check("b_timeout_cyc8", 64'(timeout_b), 64'd1);
    check("b_busy_cyc8", 64'(busy_b), 64'd1);
    wait_done_b(40);
    check("b_beats_1", 64'(beats_b), 64'd4);
    check("b_queue_empty_1", 64'(q_b.size()), 64'd0);

    // start_i in DONE repeats the same 4 beats; timeout unchanged.
    push_b4();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done_b(40);
    check("b_beats_2", 64'(beats_b), 64'd8);
    check("b_queue_empty_2", 64'(q_b.size()), 64'd0);
    check("b_timeout_sticky", 64'(timeout_b), 64'd1);

    // Trigger on the expiry cycle wins; timeout stays 0.
    rst_b = 1'b1;
    #1;
    check("b_rst_timeout", 64'(timeout_b), 64'd0);
    check("b_rst_done", 64'(done_b), 64'd0);
    push_b4();
    tick(1);
    rst_b = 1'b0;
    tick(7);
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    check("b_trig_timeout", 64'(timeout_b), 64'd0);
    check("b_trig_busy", 64'(busy_b), 64'd1);
    wait_done_b(40);
    check("b_beats_3", 64'(beats_b), 64'd12);
    check("b_queue_empty_3", 64'(q_b.size()), 64'd0);
    check("b_timeout_final", 64'(timeout_b), 64'd0);
    check("b_no_mem_write", 64'(wen_viol_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
